dlx_commit_tracer: RTL and testbench

Captures architectural side effects retired by the `dlxpipeline` core: register write-backs and data-memory stores. It orders them, tags each with a sequence number, buffers them in a FIFO and presents them on a valid/ready stream. Stimulus flows into the core through instruction fetch; this block carries results back out to a bench scoreboard, a debug UART or a trace memory. It sits beside the core and observes its write-back and memory-store ports.

---
 rtl/dlx_trace_pkg.sv | 22 ++
 rtl/dlx_trace_fifo.sv | 72 +++++++
 rtl/dlx_commit_tracer.sv | 116 +++++++++++
 tb/tb_dlx_commit_tracer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_trace_pkg.sv
// Shared types and widths for the commit tracer and its FIFO.
package dlx_trace_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned DROP_W    = 16;
    // Widest sequence number an entry can carry; narrower counters zero-extend.
    localparam int unsigned SEQ_MAX_W = 32;

    typedef enum logic {
        TRC_REG   = 1'b0,
        TRC_STORE = 1'b1
    } trace_kind_t;

    typedef struct packed {
        trace_kind_t          kind;
        logic [DATA_W-1:0]    addr;
        logic [DATA_W-1:0]    data;
        logic [SEQ_MAX_W-1:0] seq;
    } trace_entry_t;

endpackage

// File: rtl/dlx_trace_fifo.sv
// Dual-push, single-pop show-ahead FIFO with a registered head entry.
module dlx_trace_fifo
    import dlx_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       push_cnt,
    input  trace_entry_t     push_a,
    input  trace_entry_t     push_b,
    input  logic             pop,
    output logic             head_valid,
    output trace_entry_t     head,
    output logic [CNT_W-1:0] count
);

    trace_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_next;
    logic             pop_eff;
    logic             head_from_mem;
    trace_entry_t     head_next;

    // Next head: the oldest entry still stored after the pop, else the first push.
    always_comb begin
        pop_eff       = pop & head_valid;
        rd_next       = rd_ptr + PTR_W'(pop_eff);
        count_next    = count + CNT_W'(push_cnt) - CNT_W'(pop_eff);
        head_from_mem = count > CNT_W'(pop_eff);
        head_next     = head;
        if (head_from_mem) begin
            head_next = mem[rd_next];
        end else if (push_cnt != 2'd0) begin
            head_next = push_a;
        end
    end

    // Entry storage; the caller only pushes into free slots.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (push_cnt != 2'd0) begin
                mem[wr_ptr] <= push_a;
            end
            if (push_cnt == 2'd2) begin
                mem[wr_ptr + PTR_W'(1)] <= push_b;
            end
        end
    end

    // Pointers, occupancy and the registered head.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr     <= rd_next;
            count      <= count_next;
            head_valid <= count_next != '0;
            head       <= head_next;
        end
    end

endmodule

// File: rtl/dlx_commit_tracer.sv
// Orders retired write-backs and stores, tags them with sequence numbers and streams them out.
module dlx_commit_tracer
    import dlx_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned SEQ_W = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              st_en,
    input  logic [DATA_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              clear,
    input  logic              trc_ready,
    output logic              trc_valid,
    output logic              trc_kind,
    output logic [DATA_W-1:0] trc_addr,
    output logic [DATA_W-1:0] trc_data,
    output logic [SEQ_W-1:0]  trc_seq,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned FREE_W = CNT_W + 1;
    localparam int unsigned SUM_W  = DROP_W + 1;

    logic              reg_ev;
    logic              st_ev;
    logic              pop;
    logic [1:0]        n_ev;
    logic [1:0]        n_acc;
    logic [1:0]        n_drop;
    logic [FREE_W-1:0] free;
    trace_entry_t      reg_ent;
    trace_entry_t      st_ent;
    trace_entry_t      push_a;
    trace_entry_t      push_b;
    trace_entry_t      head;
    logic [SEQ_W-1:0]  seq_q;
    logic [SEQ_W-1:0]  seq_next;
    logic [DROP_W-1:0] drop_base;
    logic [SUM_W-1:0]  drop_sum;
    logic [DROP_W-1:0] drop_next;
    logic              ovf_next;

    // Qualify events, split them into accepted and dropped, and build the entries.
    always_comb begin
        reg_ev = wb_en && (wb_reg != '0);
        st_ev  = st_en;
        pop    = trc_valid & trc_ready;
        n_ev   = 2'(reg_ev) + 2'(st_ev);
        free   = FREE_W'(DEPTH) - FREE_W'(count) + FREE_W'(pop);
        n_acc  = n_ev;
        if (free < FREE_W'(n_ev)) begin
            n_acc = 2'(free);
        end
        n_drop = n_ev - n_acc;

        reg_ent = '{kind: TRC_REG, addr: DATA_W'(wb_reg), data: wb_data,
                    seq: SEQ_MAX_W'(seq_q)};
        st_ent  = '{kind: TRC_STORE, addr: st_addr, data: st_data,
                    seq: SEQ_MAX_W'(reg_ev ? seq_q + SEQ_W'(1) : seq_q)};
        push_a  = reg_ev ? reg_ent : st_ent;
        push_b  = st_ent;

        seq_next  = seq_q + SEQ_W'(n_ev);
        drop_base = clear ? '0 : drop_cnt;
        drop_sum  = SUM_W'(drop_base) + SUM_W'(n_drop);
        drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        ovf_next  = (n_drop != 2'd0) | (overflow & ~clear);
    end

    // Sequence counter and loss bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            seq_q    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            seq_q    <= seq_next;
            overflow <= ovf_next;
            drop_cnt <= drop_next;
        end
    end

    dlx_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_cnt   (n_acc),
        .push_a     (push_a),
        .push_b     (push_b),
        .pop        (pop),
        .head_valid (trc_valid),
        .head       (head),
        .count      (count)
    );

    assign trc_kind = head.kind;
    assign trc_addr = head.addr;
    assign trc_data = head.data;
    assign trc_seq  = head.seq[SEQ_W-1:0];

    // Entries carry the widest sequence field; the bits above SEQ_W are always zero.
    if (SEQ_W < SEQ_MAX_W) begin : g_seq_hi
        logic [SEQ_MAX_W-SEQ_W-1:0] seq_hi_unused;
        assign seq_hi_unused = head.seq[SEQ_MAX_W-1:SEQ_W];
    end

endmodule

// File: tb/tb_dlx_commit_tracer.sv
// Randomised and directed bench for dlx_commit_tracer with a queue-based reference model.
module tb_dlx_commit_tracer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SEQ_W = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             kind;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [SEQ_W-1:0] seq;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              wb_en = 1'b0;
    logic [4:0]        wb_reg = '0;
    logic [31:0]       wb_data = '0;
    logic              st_en = 1'b0;
    logic [31:0]       st_addr = '0;
    logic [31:0]       st_data = '0;
    logic              clear = 1'b0;
    logic              trc_ready = 1'b0;
    logic              trc_valid;
    logic              trc_kind;
    logic [31:0]       trc_addr;
    logic [31:0]       trc_data;
    logic [SEQ_W-1:0]  trc_seq;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [15:0]       drop_cnt;

    dlx_commit_tracer #(
        .DEPTH (DEPTH),
        .SEQ_W (SEQ_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .st_en     (st_en),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .clear     (clear),
        .trc_ready (trc_ready),
        .trc_valid (trc_valid),
        .trc_kind  (trc_kind),
        .trc_addr  (trc_addr),
        .trc_data  (trc_data),
        .trc_seq   (trc_seq),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial forever #5 clock = ~clock;

    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the queue is the trace buffer contents in delivery order.
    exp_t exp_q[$];
    int   model_count = 0;
    int   seq_m = 0;
    int   drops_m = 0;
    bit   ovf_m = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        check("trc_valid", 128'(trc_valid), 128'(model_count > 0));
        check("count", 128'(count), 128'(model_count));
        check("overflow", 128'(overflow), 128'(ovf_m));
        check("drop_cnt", 128'(drop_cnt), 128'(drops_m));
    endtask

    // One clock cycle: check current state, drive inputs, advance the model, clock.
    task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic se, input logic [31:0] sa, input logic [31:0] sd,
                        input logic clr, input logic rdy);
        exp_t ev[$];
        int   free;
        int   pop;
        int   nd;
        int   base;
        check_state();
        wb_en = we; wb_reg = wr; wb_data = wd;
        st_en = se; st_addr = sa; st_data = sd;
        clear = clr; trc_ready = rdy;

        pop  = (model_count > 0 && rdy) ? 1 : 0;
        free = DEPTH - model_count + pop;
        if (we && wr != 5'd0) begin
            ev.push_back('{kind: 1'b0, addr: 32'(wr), data: wd, seq: SEQ_W'(seq_m)});
            seq_m = (seq_m + 1) % (1 << SEQ_W);
        end
        if (se) begin
            ev.push_back('{kind: 1'b1, addr: sa, data: sd, seq: SEQ_W'(seq_m)});
            seq_m = (seq_m + 1) % (1 << SEQ_W);
        end
        nd = 0;
        foreach (ev[i]) begin
            if (free > 0) begin
                exp_q.push_back(ev[i]);
                model_count++;
                free--;
            end else begin
                nd++;
            end
        end
        model_count -= pop;
        base    = clr ? 0 : drops_m;
        drops_m = (base + nd > 65535) ? 65535 : base + nd;
        if (nd > 0)   ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;

        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    // Reset with noisy inputs; everything in the reset cycles must be ignored.
    task automatic reset_dut(input int n);
        reset = 1'b1;
        wb_en = 1'b1; wb_reg = 5'd9; wb_data = 32'hBAD0_0001;
        st_en = 1'b1; st_addr = 32'h40; st_data = 32'hBAD0_0002;
        clear = 1'b0; trc_ready = 1'b1;
        exp_q.delete();
        model_count = 0; seq_m = 0; drops_m = 0; ovf_m = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_fields", 128'({trc_kind, trc_addr, trc_data, trc_seq}), 128'(0));
    endtask

    // Monitor: every handshake must deliver the oldest outstanding expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && trc_valid && trc_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got seq %0d with nothing expected at %0t",
                             trc_seq, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("entry", 128'({trc_kind, trc_addr, trc_data, trc_seq}), 128'(e));
                end
            end
        end
    end

    initial begin
        int phase;
        int rdy_pct;

        // Single register write
        reset_dut(2);
        step(1, 5, 32'h1E, 0, 0, 0, 0, 1);
        check("single_valid", 128'({trc_valid, trc_kind, trc_addr, trc_data, trc_seq}),
              128'({1'b1, 1'b0, 32'd5, 32'h1E, 16'd0}));
        idle(2, 1);

        // R0 write consumes nothing
        reset_dut(1);
        step(1, 0, 32'hDEAD, 0, 0, 0, 0, 1);
        step(1, 7, 32'h77, 0, 0, 0, 0, 1);
        check("r0_next_seq", 128'(trc_seq), 128'(0));
        idle(2, 1);

        // Simultaneous register and store
        reset_dut(1);
        step(1, 3, 32'h1E, 1, 32'h8, 32'h1E, 0, 1);
        idle(3, 1);

        // Fill and overflow
        reset_dut(1);
        for (int i = 0; i < 16; i++) step(1, 5'(i % 31 + 1), 32'(i * 3), 0, 0, 0, 0, 0);
        check("fill_count", 128'(count), 128'(16));
        step(1, 5'd20, 32'h17, 0, 0, 0, 0, 0);
        check("fill_drop", 128'({overflow, drop_cnt}), 128'({1'b1, 16'd1}));
        idle(17, 1);
        step(1, 5'd21, 32'h18, 0, 0, 0, 0, 1);
        check("after_drop_seq", 128'(trc_seq), 128'(17));
        idle(2, 1);

        // Partial room, then clear
        reset_dut(1);
        for (int i = 0; i < 15; i++) step(1, 5'd4, 32'(i), 0, 0, 0, 0, 0);
        step(1, 5'd6, 32'hAA, 1, 32'h100, 32'hBB, 0, 0);
        check("partial_drop", 128'({count, drop_cnt}), 128'({5'd16, 16'd1}));
        step(0, 0, 0, 0, 0, 0, 1, 0);
        check("clear", 128'({overflow, drop_cnt}), 128'(0));
        idle(18, 1);

        // Full with pop, then reset during a stall
        reset_dut(1);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 32'(i * 4), 32'(i), 0, 0);
        step(1, 5'd9, 32'h99, 0, 0, 0, 0, 1);
        check("full_pop", 128'({count, overflow}), 128'({5'd16, 1'b0}));
        idle(3, 0);
        reset_dut(1);
        check("stall_reset", 128'({trc_valid, count}), 128'(0));
        idle(1, 1);

        // Randomised traffic with ready phases, clears and occasional resets
        for (int i = 0; i < 3000; i++) begin
            phase   = (i / 100) % 3;
            rdy_pct = (phase == 0) ? 90 : (phase == 1) ? 15 : 50;
            if ($urandom_range(0, 499) == 0) begin
                reset_dut(1);
            end else begin
                step(1'($urandom_range(0, 99) < 60), 5'($urandom), $urandom,
                     1'($urandom_range(0, 99) < 40), $urandom, $urandom,
                     1'($urandom_range(0, 29) == 0),
                     1'($urandom_range(0, 99) < rdy_pct));
            end
        end

        idle(DEPTH + 3, 1);
        check("drain_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
